// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the 4-master system bus arbiter: active-low enable
// levels, reset level, owner encoding and the round-robin pick helper.
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

  // Active-low control levels used by every bus master handshake.
  localparam logic ENABLE_      = 1'b0;
  localparam logic DISABLE_     = 1'b1;
  localparam logic RESET_ENABLE = 1'b0;

  localparam int BUS_OWNER_BUS = 2;

  typedef enum logic [BUS_OWNER_BUS-1:0] {
    BUS_OWNER_MASTER_0 = 2'd0,
    BUS_OWNER_MASTER_1 = 2'd1,
    BUS_OWNER_MASTER_2 = 2'd2,
    BUS_OWNER_MASTER_3 = 2'd3
  } bus_owner_e;

  // First requester among a, b, c (in that priority); dflt when none request.
  function automatic bus_owner_e first_req(input logic [3:0] req_n,
                                           input bus_owner_e a,
                                           input bus_owner_e b,
                                           input bus_owner_e c,
                                           input bus_owner_e dflt);
    if      (req_n[a] == ENABLE_) return a;
    else if (req_n[b] == ENABLE_) return b;
    else if (req_n[c] == ENABLE_) return c;
    else                          return dflt;
  endfunction

endpackage

// File: rtl/bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_arbiter_if
// Control signals between the bus masters and the arbiter.
//   mX_req_n   : master X request, active-low
//   mX_grnt_n  : master X grant, active-low
//   owner      : current bus owner, select for the master mux
//   tmo_err    : sticky hold-time watchdog error
//   tmo_owner  : owner captured when tmo_err was set
//   tmo_clr    : synchronous clear of tmo_err/tmo_owner, active-high
// Modports: slave = arbiter side, master = masters / system side.
// -----------------------------------------------------------------------------
interface bus_arbiter_if;
  logic       m0_req_n, m1_req_n, m2_req_n, m3_req_n;
  logic       m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n;
  logic [1:0] owner;
  logic       tmo_err;
  logic [1:0] tmo_owner;
  logic       tmo_clr;

  modport slave (
    input  m0_req_n, m1_req_n, m2_req_n, m3_req_n, tmo_clr,
    output m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n,
           owner, tmo_err, tmo_owner
  );

  modport master (
    output m0_req_n, m1_req_n, m2_req_n, m3_req_n, tmo_clr,
    input  m0_grnt_n, m1_grnt_n, m2_grnt_n, m3_grnt_n,
           owner, tmo_err, tmo_owner
  );
endinterface

// File: rtl/bus_arb_wdt.sv
// -----------------------------------------------------------------------------
// bus_arb_wdt
// Hold-time watchdog for the bus arbiter. Counts consecutive cycles the same
// owner keeps its request asserted, saturating at TMO_CYCLES, and raises a
// sticky error that records the first offending owner.
//   clk, reset     : clock, asynchronous active-low reset
//   i_owner        : current owner
//   i_owner_req_n  : request of the current owner (active-low)
//   i_owner_chg    : owner changes on this edge
//   i_tmo_clr      : synchronous clear of the error, active-high
//   o_tmo_err      : sticky timeout flag
//   o_tmo_owner    : owner captured when the flag was set
// -----------------------------------------------------------------------------
module bus_arb_wdt
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 256,
  parameter bit          TMO_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  bus_owner_e i_owner,
  input  logic       i_owner_req_n,
  input  logic       i_owner_chg,
  input  logic       i_tmo_clr,
  output logic       o_tmo_err,
  output bus_owner_e o_tmo_owner
);

  if (TMO_EN) begin : g_wdt
    localparam logic [15:0] TMO_LIM = 16'(TMO_CYCLES);

    logic [15:0] r_cnt;
    logic [15:0] w_cnt_nxt;
    logic        w_held;
    logic        w_hit;
    logic        r_tmo_err;
    bus_owner_e  r_tmo_owner;

    assign w_held = (i_owner_req_n == ENABLE_) && !i_owner_chg;

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
      w_cnt_nxt = '0;
      if (w_held) begin
        w_cnt_nxt = (r_cnt >= TMO_LIM) ? r_cnt : r_cnt + 16'd1;
      end
    end

    // Fires on every held edge at the limit, so a cleared error re-asserts
    // while the same owner keeps holding a saturated counter.
    assign w_hit = w_held && (w_cnt_nxt == TMO_LIM);

    // NOTE: sequential state uses non-blocking assignments so all registers
    // update together from pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
      if (reset == RESET_ENABLE) begin
        r_cnt       <= '0;
        r_tmo_err   <= 1'b0;
        r_tmo_owner <= BUS_OWNER_MASTER_0;
      end else begin
        r_cnt <= w_cnt_nxt;
        // Set beats clear; an existing error keeps its first offender.
        if (w_hit && !r_tmo_err) begin
          r_tmo_err   <= 1'b1;
          r_tmo_owner <= i_owner;
        end else if (i_tmo_clr) begin
          r_tmo_err   <= 1'b0;
          r_tmo_owner <= BUS_OWNER_MASTER_0;
        end
      end
    end

    assign o_tmo_err   = r_tmo_err;
    assign o_tmo_owner = r_tmo_owner;
  end else begin : g_off
    logic w_unused_ok;
    assign w_unused_ok = ^{clk, reset, i_owner, i_owner_req_n, i_owner_chg, i_tmo_clr};
    assign o_tmo_err   = 1'b0;
    assign o_tmo_owner = BUS_OWNER_MASTER_0;
  end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin arbiter for the 4-master system bus. The owner keeps the bus
// until it drops its request; the grant then moves to the next requester in
// order owner+1..owner+3. With no requests the bus stays parked on the last
// owner. Grants are a glitch-free decode of the owner register.
//   clk    : system clock
//   reset  : asynchronous reset, active-low
//   bus    : bus_arbiter_if.slave (requests, grants, owner, watchdog)
// -----------------------------------------------------------------------------
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned TMO_CYCLES = 256,
  parameter bit          TMO_EN     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  bus_arbiter_if.slave       bus
);

  logic [3:0] w_req_n;
  logic       w_owner_req_n;
  logic       w_owner_chg;
  bus_owner_e r_owner;
  bus_owner_e w_owner_nxt;
  bus_owner_e w_tmo_owner;
  logic       w_tmo_err;

  assign w_req_n       = {bus.m3_req_n, bus.m2_req_n, bus.m1_req_n, bus.m0_req_n};
  assign w_owner_req_n = w_req_n[r_owner];

  always_comb begin
    w_owner_nxt = r_owner;
    if (w_owner_req_n != ENABLE_) begin
      case (r_owner)
        BUS_OWNER_MASTER_0: w_owner_nxt = first_req(w_req_n, BUS_OWNER_MASTER_1,
                              BUS_OWNER_MASTER_2, BUS_OWNER_MASTER_3, r_owner);
        BUS_OWNER_MASTER_1: w_owner_nxt = first_req(w_req_n, BUS_OWNER_MASTER_2,
                              BUS_OWNER_MASTER_3, BUS_OWNER_MASTER_0, r_owner);
        BUS_OWNER_MASTER_2: w_owner_nxt = first_req(w_req_n, BUS_OWNER_MASTER_3,
                              BUS_OWNER_MASTER_0, BUS_OWNER_MASTER_1, r_owner);
        BUS_OWNER_MASTER_3: w_owner_nxt = first_req(w_req_n, BUS_OWNER_MASTER_0,
                              BUS_OWNER_MASTER_1, BUS_OWNER_MASTER_2, r_owner);
        default:            w_owner_nxt = r_owner;
      endcase
    end
  end

  assign w_owner_chg = (w_owner_nxt != r_owner);

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_owner <= BUS_OWNER_MASTER_0;
    end else begin
      r_owner <= w_owner_nxt;
    end
  end

  // Grants decode a register directly, so exactly one is low at all times.
  assign bus.m0_grnt_n = (r_owner == BUS_OWNER_MASTER_0) ? ENABLE_ : DISABLE_;
  assign bus.m1_grnt_n = (r_owner == BUS_OWNER_MASTER_1) ? ENABLE_ : DISABLE_;
  assign bus.m2_grnt_n = (r_owner == BUS_OWNER_MASTER_2) ? ENABLE_ : DISABLE_;
  assign bus.m3_grnt_n = (r_owner == BUS_OWNER_MASTER_3) ? ENABLE_ : DISABLE_;
  assign bus.owner     = r_owner;

  bus_arb_wdt #(
    .TMO_CYCLES (TMO_CYCLES),
    .TMO_EN     (TMO_EN)
  ) u_wdt (
    .clk           (clk),
    .reset         (reset),
    .i_owner       (r_owner),
    .i_owner_req_n (w_owner_req_n),
    .i_owner_chg   (w_owner_chg),
    .i_tmo_clr     (bus.tmo_clr),
    .o_tmo_err     (w_tmo_err),
    .o_tmo_owner   (w_tmo_owner)
  );

  assign bus.tmo_err   = w_tmo_err;
  assign bus.tmo_owner = w_tmo_owner;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. A watchdog-enabled instance with an
// 8-cycle limit is checked against expected owner / grant / error values; a
// watchdog-disabled instance shares its inputs and must arbitrate identically
// with tmo_err held low.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_if bus ();
  bus_arbiter_if bus_ne ();

  assign bus_ne.m0_req_n = bus.m0_req_n;
  assign bus_ne.m1_req_n = bus.m1_req_n;
  assign bus_ne.m2_req_n = bus.m2_req_n;
  assign bus_ne.m3_req_n = bus.m3_req_n;
  assign bus_ne.tmo_clr  = bus.tmo_clr;

  bus_arbiter #(.TMO_CYCLES(8), .TMO_EN(1'b1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  bus_arbiter #(.TMO_CYCLES(2), .TMO_EN(1'b0)) dut_ne (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_ne)
  );

  typedef struct {
    logic [3:0] req_n;   // {m3,m2,m1,m0}
    logic       clr;
    logic [1:0] owner;
    logic       err;
    logic [1:0] towner;
  } vec_t;

  typedef struct {
    logic [1:0] owner;
    logic       err;
    logic [1:0] towner;
    string      name;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[22];
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] req_n, input logic clr);
    bus.m0_req_n = req_n[0];
    bus.m1_req_n = req_n[1];
    bus.m2_req_n = req_n[2];
    bus.m3_req_n = req_n[3];
    bus.tmo_clr  = clr;
  endtask

  task automatic check_outputs(input exp_t e);
    logic [3:0] g;
    g = 4'b1111;
    g[e.owner] = 1'b0;
    check({e.name, ".owner"}, 32'(bus.owner), 32'(e.owner));
    check({e.name, ".grnt"},
          32'({bus.m3_grnt_n, bus.m2_grnt_n, bus.m1_grnt_n, bus.m0_grnt_n}), 32'(g));
    check({e.name, ".err"}, 32'(bus.tmo_err), 32'(e.err));
    check({e.name, ".towner"}, 32'(bus.tmo_owner), 32'(e.towner));
    check({e.name, ".ne_owner"}, 32'(bus_ne.owner), 32'(e.owner));
    check({e.name, ".ne_err"}, 32'(bus_ne.tmo_err), 32'(0));
  endtask

  // Called at a falling edge: drive, queue the expectation, let one rising
  // edge pass, compare 1 time unit later, return at the next falling edge.
  task automatic step(input logic [3:0] req_n, input logic clr, input logic [1:0] owner,
                      input logic err, input logic [1:0] towner, input string name);
    exp_t e;
    drive(req_n, clr);
    sb.push_back('{owner, err, towner, name});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check_outputs(e);
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    exp_t e;
    // Parked release, single requester, fair rotation, search order,
    // simultaneous release/request. Every hold is far below the 8-cycle limit.
    vecs = '{
      '{4'b1111, 1'b0, 2'd0, 1'b0, 2'd0},  // idle after reset: parked on 0
      '{4'b1011, 1'b0, 2'd2, 1'b0, 2'd0},  // m2 requests, m0 idle
      '{4'b1111, 1'b0, 2'd2, 1'b0, 2'd0},  // m2 releases: stays parked on 2
      '{4'b1111, 1'b0, 2'd2, 1'b0, 2'd0},
      '{4'b1110, 1'b0, 2'd0, 1'b0, 2'd0},  // m0 takes over
      '{4'b0000, 1'b0, 2'd0, 1'b0, 2'd0},  // all request, m0 holds
      '{4'b0001, 1'b0, 2'd1, 1'b0, 2'd0},  // m0 releases -> 1
      '{4'b0000, 1'b0, 2'd1, 1'b0, 2'd0},
      '{4'b0010, 1'b0, 2'd2, 1'b0, 2'd0},  // m1 releases -> 2
      '{4'b0000, 1'b0, 2'd2, 1'b0, 2'd0},
      '{4'b0100, 1'b0, 2'd3, 1'b0, 2'd0},  // m2 releases -> 3
      '{4'b0000, 1'b0, 2'd3, 1'b0, 2'd0},
      '{4'b1000, 1'b0, 2'd0, 1'b0, 2'd0},  // m3 releases -> wraps to 0
      '{4'b1111, 1'b0, 2'd0, 1'b0, 2'd0},
      '{4'b1101, 1'b0, 2'd1, 1'b0, 2'd0},  // m1 takes the bus
      '{4'b0100, 1'b0, 2'd1, 1'b0, 2'd0},  // m0,m3 request: no preemption
      '{4'b0110, 1'b0, 2'd3, 1'b0, 2'd0},  // m1 releases: search 2,3 -> 3
      '{4'b1110, 1'b0, 2'd0, 1'b0, 2'd0},  // m3 releases -> 0
      '{4'b1111, 1'b0, 2'd0, 1'b0, 2'd0},
      '{4'b1110, 1'b0, 2'd0, 1'b0, 2'd0},
      '{4'b1101, 1'b0, 2'd1, 1'b0, 2'd0},  // m0 release + m1 new request same edge
      '{4'b1111, 1'b0, 2'd1, 1'b0, 2'd0}
    };

    // Reset state, checked before any clock edge has been seen.
    drive(4'b1111, 1'b0);
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    e = '{2'd0, 1'b0, 2'd0, "reset"};
    check_outputs(e);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;

    foreach (vecs[i])
      step(vecs[i].req_n, vecs[i].clr, vecs[i].owner, vecs[i].err, vecs[i].towner,
           $sformatf("vec%0d", i));

    // Parked on m1: its grant is already present before any edge.
    drive(4'b1101, 1'b0);
    #1;
    check("park_grant_m1", 32'(bus.m1_grnt_n), 32'(0));

    // m1 holds 10 cycles: error on the 8th held edge, grant never revoked.
    for (int h = 1; h <= 10; h++)
      step(4'b1101, 1'b0, 2'd1, (h >= 8), (h >= 8) ? 2'd1 : 2'd0,
           $sformatf("hold%0d", h));
    step(4'b1101, 1'b1, 2'd1, 1'b0, 2'd0, "clr1");
    step(4'b1101, 1'b0, 2'd1, 1'b1, 2'd1, "reset_sat");
    step(4'b1101, 1'b1, 2'd1, 1'b0, 2'd0, "clr2");
    step(4'b1101, 1'b1, 2'd1, 1'b1, 2'd1, "set_wins");

    // m1 releases, m3 owns and times out too: first offender is kept.
    step(4'b0111, 1'b0, 2'd3, 1'b1, 2'd1, "to_m3");
    for (int h = 1; h <= 8; h++)
      step(4'b0111, 1'b0, 2'd3, 1'b1, 2'd1, $sformatf("m3hold%0d", h));
    step(4'b0111, 1'b1, 2'd3, 1'b0, 2'd0, "clr3");
    step(4'b0111, 1'b0, 2'd3, 1'b1, 2'd3, "new_offender");

    // m2 mid-tenure, then asynchronous reset between clock edges.
    step(4'b1011, 1'b0, 2'd2, 1'b1, 2'd3, "to_m2");
    step(4'b1011, 1'b0, 2'd2, 1'b1, 2'd3, "m2_hold");
    #2 reset = 1'b0;
    #1;
    e = '{2'd0, 1'b0, 2'd0, "async_rst"};
    check_outputs(e);
    check("async_rst.cnt", 32'(dut.u_wdt.g_wdt.r_cnt), 32'(0));
    @(negedge clk);
    drive(4'b1111, 1'b0);
    reset = 1'b1;
    step(4'b1111, 1'b0, 2'd0, 1'b0, 2'd0, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Round-robin arbiter for the 4-master shared system bus.
- Each master (CPU bus interfaces, DMA) raises an active-low request and waits for an active-low grant before driving address strobe.
- The arbiter keeps ownership with the current master until it drops its request.
- A hold-time watchdog flags any master that keeps the bus too long.
- Sits in the Bus directory between the masters' control signals and the bus master multiplexer, which is driven from the owner output.

Parameters:
- TMO_CYCLES, 256, consecutive held cycles of one owner before the timeout error is flagged; legal range 1..65535.
- TMO_EN, 1, 1 enables the watchdog; 0 ties tmo_err low and holds the counter at 0.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset  in  1  asynchronous reset, active-low
- m0_req_n  in  1  master 0 bus request, active-low
- m1_req_n  in  1  master 1 bus request, active-low
- m2_req_n  in  1  master 2 bus request, active-low
- m3_req_n  in  1  master 3 bus request, active-low
- m0_grnt_n  out  1  master 0 grant, active-low
- m1_grnt_n  out  1  master 1 grant, active-low
- m2_grnt_n  out  1  master 2 grant, active-low
- m3_grnt_n  out  1  master 3 grant, active-low
- owner  out  2  index of the current bus owner; select for the master mux
- tmo_err  out  1  sticky watchdog error flag
- tmo_owner  out  2  owner index captured when tmo_err set
- tmo_clr  in  1  synchronous clear of tmo_err/tmo_owner, active-high

Behaviour:
- Reset (reset low, asynchronous): owner=0, tmo_cnt=0, tmo_err=0, tmo_owner=0. Grant outputs follow owner, so m0_grnt_n=0 and the others are 1 while in reset and after release.
- Grants are a pure decode of the owner register: mX_grnt_n = ENABLE_ iff owner==X. Exactly one grant is always asserted (bus parking). No grant glitch is allowed between owners.
- Ownership update, evaluated on each rising edge:
  - If req_n[owner]==ENABLE_: owner is held.
  - Else, search owner+1, owner+2, owner+3 (mod 4) and take the first index with req_n==ENABLE_.
  - If no master requests, owner is unchanged (parked).
- Latency:
  - A requester seeing a parked grant on itself gets the grant in 0 cycles.
  - Otherwise the grant moves on the first edge after the current owner deasserts its request, i.e. a 1-cycle release-to-grant gap.
- Fairness: with all four masters requesting and each releasing after use, ownership cycles 0→1→2→3→0. Worst-case wait is 3 tenures plus 3 cycles.
- Simultaneous events: owner release and a new request arriving on the same edge are both sampled on that edge, so the new requester is eligible. Requests by non-owners never preempt the owner.
- Watchdog, when TMO_EN=1:
  - tmo_cnt (16 bit) increments each cycle that req_n[owner]==ENABLE_ and clears to 0 on any owner change or owner release.
  - tmo_cnt saturates at TMO_CYCLES.
  - On the edge where tmo_cnt reaches TMO_CYCLES, tmo_err<=1 and tmo_owner<=owner, unless tmo_err is already 1; the first offender is kept.
  - Ownership is never revoked by the watchdog.
- tmo_clr: clears tmo_err and tmo_owner on the next edge. If tmo_clr and a new timeout occur on the same edge, the set wins.
- Reset mid-tenure returns the grant to master 0 immediately. Masters are reset in the same domain.

Decomposition:
- Shared package (bus_def.v): BUS_OWNER_BUS (1:0) and BUS_OWNER_MASTER_0..3 constants.
- Shared package (global_std_def.v): ENABLE_/DISABLE_, RESET_EDGE, RESET_ENABLE, already present and used unchanged.
- One sub-module: bus_arb_wdt, containing the hold counter, saturation and sticky error capture. Inputs: owner, owner_req_n, owner_chg, tmo_clr. Outputs: tmo_err, tmo_owner.
- Round-robin next-owner search stays in bus_arbiter as a combinational case on owner.

Test Plan:
- Reset release, no requests → m0_grnt_n=0, m1..m3_grnt_n=1, owner=0, tmo_err=0.
- Owner 0 parked; m2_req_n=0 for 1 cycle, then m0 idle → owner=2 on the next edge, m2_grnt_n=0; after m2 releases with no requests, owner stays 2.
- All four req_n=0, each owner releases 2 cycles after receiving grant → owner sequence 0,1,2,3,0, each grant 1 cycle after the previous release, never two grants low at once.
- Owner 1 holds; m0 and m3 request; m1 releases → owner=3 (search order 2,3,0); m3 releases → owner=0.
- TMO_CYCLES=8, m1 holds 10 cycles → tmo_err=1 on the 8th held edge, tmo_owner=1, grant kept. Pulse tmo_clr → tmo_err=0 next edge. Hold continues with counter saturated → tmo_err re-set on the following edge.
- m2 owns mid-tenure, reset pulsed low asynchronously → owner=0, m0_grnt_n=0, tmo_cnt=0 without waiting for clk.
